// File: rtl/mimosa_pkg.sv
// Shared mimosa definitions: emotion codes, heartbeat levels and the level type.
package mimosa_pkg;

    localparam int unsigned EMO_W = 8;
    localparam int unsigned HB_W  = 2;

    typedef logic [HB_W-1:0] heartbeat_t;

    localparam logic [EMO_W-1:0] EMO_NEUTRAL  = 8'h00;
    localparam logic [EMO_W-1:0] EMO_CONTENT  = 8'h01;
    localparam logic [EMO_W-1:0] EMO_BORED    = 8'h02;
    localparam logic [EMO_W-1:0] EMO_HAPPY    = 8'h03;
    localparam logic [EMO_W-1:0] EMO_SAD      = 8'h04;
    localparam logic [EMO_W-1:0] EMO_EXCITED  = 8'h05;
    localparam logic [EMO_W-1:0] EMO_STRESSED = 8'h06;
    localparam logic [EMO_W-1:0] EMO_ANGRY    = 8'h07;
    localparam logic [EMO_W-1:0] EMO_AFRAID   = 8'h08;
    localparam logic [EMO_W-1:0] EMO_PANIC    = 8'h09;

    localparam heartbeat_t HB_SLOW   = 2'b00;
    localparam heartbeat_t HB_NORMAL = 2'b01;
    localparam heartbeat_t HB_FAST   = 2'b10;
    localparam heartbeat_t HB_RACING = 2'b11;

endpackage

// File: rtl/heartbeat_model_core_if.sv
// Emotion/sleep inputs and heartbeat level output of the heartbeat model.
interface heartbeat_model_core_if;
    import mimosa_pkg::*;

    logic [EMO_W-1:0] emotion;
    logic             sleeping;
    heartbeat_t       heartbeat;

    modport master (output emotion, output sleeping, input heartbeat);
    modport slave  (input emotion, input sleeping, output heartbeat);

endinterface

// File: rtl/heartbeat_target_map.sv
// Combinational map from emotion code and sleep flag to the target heartbeat level.
module heartbeat_target_map
    import mimosa_pkg::*;
(
    input  logic [EMO_W-1:0] emotion,
    input  logic             sleeping,
    output heartbeat_t       target
);

    // Sleep overrides any emotion; unknown codes fall back to NORMAL.
    always_comb begin
        target = HB_NORMAL;
        if (sleeping) begin
            target = HB_SLOW;
        end else begin
            unique case (emotion)
                EMO_NEUTRAL:  target = HB_NORMAL;
                EMO_CONTENT:  target = HB_SLOW;
                EMO_BORED:    target = HB_SLOW;
                EMO_HAPPY:    target = HB_NORMAL;
                EMO_SAD:      target = HB_NORMAL;
                EMO_EXCITED:  target = HB_FAST;
                EMO_STRESSED: target = HB_FAST;
                EMO_ANGRY:    target = HB_RACING;
                EMO_AFRAID:   target = HB_RACING;
                EMO_PANIC:    target = HB_RACING;
                default:      target = HB_NORMAL;
            endcase
        end
    end

endmodule

// File: rtl/heartbeat_model_core.sv
// Heartbeat slew model: moves the registered level one step toward the target
// every STEP_CYCLES cycles of sustained mismatch.
module heartbeat_model_core
    import mimosa_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    heartbeat_model_core_if.slave bus
);

    localparam int unsigned CNT_RAW = $clog2(STEP_CYCLES + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    heartbeat_t       target;
    heartbeat_t       hb_q;
    heartbeat_t       hb_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    heartbeat_target_map u_map (
        .emotion  (bus.emotion),
        .sleeping (bus.sleeping),
        .target   (target)
    );

    // State register; reset aborts any ramp in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_q  <= HB_NORMAL;
            cnt_q <= '0;
        end else begin
            hb_q  <= hb_d;
            cnt_q <= cnt_d;
        end
    end

    // Counter survives target changes; direction follows the current target.
    always_comb begin
        hb_d  = hb_q;
        cnt_d = '0;
        if (hb_q != target) begin
            if (cnt_q == CNT_LAST) begin
                hb_d = (target > hb_q) ? hb_q + HB_W'(1) : hb_q - HB_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.heartbeat = hb_q;

endmodule

// File: tb/tb_heartbeat_model_core.sv
// Self-checking bench for heartbeat_model_core with STEP_CYCLES of 4 and 1.
module tb_heartbeat_model_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] emotion = 8'h00;
    logic       sleeping = 1'b0;

    int errors = 0;
    int checks = 0;

    int m4_lvl = 1, m4_cnt = 0;
    int m1_lvl = 1, m1_cnt = 0;

    heartbeat_model_core_if bus4 ();
    heartbeat_model_core_if bus1 ();

    assign bus4.emotion  = emotion;
    assign bus4.sleeping = sleeping;
    assign bus1.emotion  = emotion;
    assign bus1.sleeping = sleeping;

    heartbeat_model_core #(.STEP_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    heartbeat_model_core #(.STEP_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    // Target level straight from the emotion table.
    function automatic int ref_target(logic s, logic [7:0] e);
        int lut [10] = '{1, 0, 0, 1, 1, 2, 2, 3, 3, 3};
        if (s) return 0;
        if (e <= 8'd9) return lut[int'(e)];
        return 1;
    endfunction

    function automatic int ref_lvl(int lvl, int cnt, int tgt, int step);
        if (lvl != tgt && cnt + 1 >= step) return (tgt > lvl) ? lvl + 1 : lvl - 1;
        return lvl;
    endfunction

    function automatic int ref_cnt(int lvl, int cnt, int tgt, int step);
        if (lvl == tgt || cnt + 1 >= step) return 0;
        return cnt + 1;
    endfunction

    // Reference model, one per instance, advanced on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m4_lvl <= 1; m4_cnt <= 0;
            m1_lvl <= 1; m1_cnt <= 0;
        end else begin
            m4_lvl <= ref_lvl(m4_lvl, m4_cnt, ref_target(sleeping, emotion), 4);
            m4_cnt <= ref_cnt(m4_lvl, m4_cnt, ref_target(sleeping, emotion), 4);
            m1_lvl <= ref_lvl(m1_lvl, m1_cnt, ref_target(sleeping, emotion), 1);
            m1_cnt <= ref_cnt(m1_lvl, m1_cnt, ref_target(sleeping, emotion), 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] e);
        emotion = e; sleeping = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [1:0] exp;
        emotion = 8'h07; sleeping = 1'b0; rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (bus4.heartbeat !== 2'b01) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=01", k, bus4.heartbeat);
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = (k < 4) ? 2'b01 : (k < 8) ? 2'b10 : 2'b11;
            checks++;
            if (bus4.heartbeat !== exp) begin
                errors++;
                $display("FAIL reset_ramp edge=%0d got=%b exp=%b", k, bus4.heartbeat, exp);
            end
        end
    endtask

    task automatic test_sleep();
        logic [1:0] exp;
        do_reset(8'h00);
        sleeping = 1'b1; emotion = 8'h09;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp = (k < 4) ? 2'b01 : 2'b00;
            checks++;
            if (bus4.heartbeat !== exp) begin
                errors++;
                $display("FAIL sleep_enter edge=%0d got=%b exp=%b", k, bus4.heartbeat, exp);
            end
        end
        sleeping = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp = (k < 4) ? 2'b00 : (k < 8) ? 2'b01 : (k < 12) ? 2'b10 : 2'b11;
            checks++;
            if (bus4.heartbeat !== exp) begin
                errors++;
                $display("FAIL sleep_release edge=%0d got=%b exp=%b", k, bus4.heartbeat, exp);
            end
        end
    endtask

    task automatic test_mapping();
        logic [7:0] codes [11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                                   8'h06, 8'h07, 8'h08, 8'h09, 8'hFF};
        logic [1:0] exp;
        do_reset(8'h00);
        for (int i = 0; i < 11; i++) begin
            emotion = codes[i];
            repeat (8) tick();
            exp = 2'(ref_target(1'b0, codes[i]));
            checks++;
            if (bus1.heartbeat !== exp) begin
                errors++;
                $display("FAIL map code=%h got=%b exp=%b", codes[i], bus1.heartbeat, exp);
            end
        end
    endtask

    task automatic test_reversal();
        logic [1:0] exp;
        do_reset(8'h00);
        emotion = 8'h07;
        for (int k = 1; k <= 6; k++) begin
            if (k == 3) emotion = 8'h01;
            tick();
            exp = (k < 4) ? 2'b01 : 2'b00;
            checks++;
            if (bus4.heartbeat !== exp) begin
                errors++;
                $display("FAIL reversal edge=%0d got=%b exp=%b", k, bus4.heartbeat, exp);
            end
        end
    endtask

    task automatic test_target_reached();
        logic [1:0] exp;
        do_reset(8'h00);
        emotion = 8'h05;
        tick(); tick();
        emotion = 8'h00;
        tick();
        checks++;
        if (bus4.heartbeat !== 2'b01) begin
            errors++;
            $display("FAIL reached_hold got=%b exp=01", bus4.heartbeat);
        end
        // A cleared count means a fresh ramp needs the full interval again.
        emotion = 8'h05;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = (k < 4) ? 2'b01 : 2'b10;
            checks++;
            if (bus4.heartbeat !== exp) begin
                errors++;
                $display("FAIL reached_restart edge=%0d got=%b exp=%b", k, bus4.heartbeat, exp);
            end
        end
    endtask

    task automatic test_reset_mid_ramp();
        logic [1:0] exp;
        do_reset(8'h00);
        emotion = 8'h07;
        repeat (5) tick();
        checks++;
        if (bus4.heartbeat !== 2'b10) begin
            errors++;
            $display("FAIL midramp_pre got=%b exp=10", bus4.heartbeat);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (bus4.heartbeat !== 2'b01) begin
            errors++;
            $display("FAIL midramp_reset got=%b exp=01", bus4.heartbeat);
        end
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = (k < 4) ? 2'b01 : 2'b10;
            checks++;
            if (bus4.heartbeat !== exp) begin
                errors++;
                $display("FAIL midramp_restart edge=%0d got=%b exp=%b", k, bus4.heartbeat, exp);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset(8'h00);
        for (int n = 0; n < 600; n++) begin
            if (hold == 0) begin
                emotion  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
                sleeping = ($urandom_range(0, 7) == 0);
                hold     = int'($urandom_range(1, 14));
            end
            hold--;
            rst = ($urandom_range(0, 59) == 0);
            tick();
            checks++;
            if (bus4.heartbeat !== 2'(m4_lvl)) begin
                errors++;
                $display("FAIL rand_s4 n=%0d got=%b exp=%0d", n, bus4.heartbeat, m4_lvl);
            end
            checks++;
            if (bus1.heartbeat !== 2'(m1_lvl)) begin
                errors++;
                $display("FAIL rand_s1 n=%0d got=%b exp=%0d", n, bus1.heartbeat, m1_lvl);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_sleep();
        test_mapping();
        test_reversal();
        test_target_reached();
        test_reset_mid_ramp();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/heartbeat_model_core.md
# heartbeat_model_core

Registered heartbeat-rate model for the mimosa creature. It maps the current emotion code and the sleeping flag to a target heartbeat level, then slews a 2-bit heartbeat output toward that target by at most one level per step interval. It sits downstream of the emotion state logic and drives the heartbeat indicator and output encoding.

## Interface
- `STEP_CYCLES`, default 4: clock cycles per one-level heartbeat change; legal range 1–255.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `emotion` input 8: emotion code from the emotion state logic; codes are defined in the shared package.
- `sleeping` input 1: high while the creature sleeps.
- `heartbeat` output 2: current heartbeat level, registered.

One clock, `clk`. Reset `rst` is synchronous and active-high.

## Operation
- Heartbeat levels:
  - `2'b00` SLOW
  - `2'b01` NORMAL
  - `2'b10` FAST
  - `2'b11` RACING
- Target level is combinational from the inputs. `sleeping = 1` forces SLOW and overrides emotion. Otherwise the emotion code maps as follows:
  - `0x00` NEUTRAL → NORMAL
  - `0x01` CONTENT → SLOW
  - `0x02` BORED → SLOW
  - `0x03` HAPPY → NORMAL
  - `0x04` SAD → NORMAL
  - `0x05` EXCITED → FAST
  - `0x06` STRESSED → FAST
  - `0x07` ANGRY → RACING
  - `0x08` AFRAID → RACING
  - `0x09` PANIC → RACING
  - any other code → NORMAL
- State:
  - `heartbeat` register, 2 bits.
  - Step counter `cnt`, width `$clog2(STEP_CYCLES+1)`, minimum 1.
- Each rising edge, when `heartbeat == target`:
  - `cnt <= 0`; `heartbeat` holds.
- Each rising edge, when `heartbeat != target`:
  - If `cnt == STEP_CYCLES-1`: `heartbeat` moves one level toward the target (+1 or −1) and `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`.
- Target changes during a ramp: `cnt` is not cleared. The step direction always follows the target of the current cycle.
- If the target becomes equal to `heartbeat` mid-count, `cnt` clears on that edge.
- Level never wraps. It saturates naturally because a step only occurs toward an in-range target.
- With `STEP_CYCLES = 1`, the level steps every cycle while it is mismatched.

## Timing
- Reset, synchronous: `heartbeat <= 2'b01` (NORMAL), `cnt <= 0`.
  - `rst` has priority over all other updates.
  - Reset asserted mid-ramp aborts the ramp.
- Latency for one level: the target is valid combinationally. `heartbeat` changes on the `STEP_CYCLES`-th rising edge after the first edge where a mismatch is sampled, provided the target stays mismatched throughout.
- A full swing of N levels takes N × `STEP_CYCLES` cycles.
- No handshake. Inputs are sampled every edge and are assumed synchronous to `clk`.

## Structure
- Shared package `mimosa_pkg` holds:
  - emotion code localparams (`EMO_NEUTRAL` … `EMO_PANIC`)
  - heartbeat level localparams `HB_SLOW`, `HB_NORMAL`, `HB_FAST`, `HB_RACING`
  - a `heartbeat_t` 2-bit typedef
- One natural sub-module: `heartbeat_target_map`, a purely combinational block (`emotion`, `sleeping` → `target[1:0]`). The top level holds the counter and slew register.

## Test plan
- Reset: assert `rst` for 2 cycles with `emotion = 0x07`. Required: `heartbeat = 01` during reset and on the first edge after release, then `10` after 4 more edges and `11` after a further 4 edges.
- Sleep override: from NORMAL, apply `sleeping = 1` with `emotion = 0x09`. Required: `heartbeat = 00` exactly 4 edges later, stable thereafter. Releasing sleep returns the output to `11` in 12 edges.
- Mapping sweep: `STEP_CYCLES = 1`, `sleeping = 0`, hold each code `0x00`–`0x09` plus `0xFF` for 8 cycles. Required: final level per each code matches the map; `0xFF` gives `01`.
- Mid-ramp reversal: from `01`, set `emotion = 0x07`; after 2 edges switch to `0x01`. Required: `cnt` continues, and `heartbeat` steps to `00` on edge 4. It never reaches `10`.
- Target reached mid-count: from `01`, set `emotion = 0x05` for 2 edges, then `0x00`. Required: `heartbeat` stays `01` and `cnt` returns to 0 on the next edge.
- Reset mid-ramp: during a `01`→`11` ramp at `heartbeat = 10`, pulse `rst`. Required: `heartbeat = 01` on the reset edge, and the ramp restarts with the full 4-cycle interval.
